// File: rtl/apb_master_arb_if.sv
// APB bus bundle shared by the arbitrating master and the slave it drives.
interface apb_master_arb_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel,
        output penable,
        output pwrite,
        output paddr,
        output pwdata,
        output pstrb,
        input  prdata,
        input  pready,
        input  pslverr
    );

    modport slave (
        input  psel,
        input  penable,
        input  pwrite,
        input  paddr,
        input  pwdata,
        input  pstrb,
        output prdata,
        output pready,
        output pslverr
    );
endinterface

// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin arbitration, one transfer at a time
// through IDLE -> SETUP -> ACCESS, with a saturating wait-state counter and a
// sticky timeout flag.
module apb_master_arb #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic        pclk,
    input  logic        preset,

    input  logic        m0_req,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_strb,
    output logic        m0_done,

    input  logic        m1_req,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_strb,
    output logic        m1_done,

    output logic [31:0] rsp_rdata,
    output logic        rsp_slverr,
    output logic        busy,
    output logic        timeout_err,

    apb_master_arb_if.master apb
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LIMIT_W = 8'(WAIT_LIMIT);

    state_t      state;
    state_t      state_next;

    logic        start_xfer;
    logic        finish_xfer;

    logic        elig0;
    logic        elig1;
    logic        grant_any;
    logic        grant_m1;

    logic        last_m1;
    logic        owner_m1;

    logic        sel_write;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_strb;

    logic [7:0]  wait_cnt;
    logic [7:0]  wait_inc;

    // A requester whose done pulse is showing this cycle is not eligible, so a
    // held req is not mistaken for a fresh one; ties go to whoever lost last.
    always_comb begin
        elig0     = m0_req & ~m0_done;
        elig1     = m1_req & ~m1_done;
        grant_any = elig0 | elig1;
        grant_m1  = elig1 & (~elig0 | ~last_m1);
    end

    // Steer the winning requester's transfer fields toward the bus registers.
    always_comb begin
        sel_write = m0_write;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        sel_strb  = m0_strb;
        if (grant_m1) begin
            sel_write = m1_write;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
            sel_strb  = m1_strb;
        end
    end

    // State register for the bus sequencer.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the PSEL/PENABLE/busy decode of the current state.
    always_comb begin
        state_next  = state;
        start_xfer  = 1'b0;
        finish_xfer = 1'b0;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        busy        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_any) begin
                    state_next = ST_SETUP;
                    start_xfer = 1'b1;
                end
            end
            ST_SETUP: begin
                apb.psel   = 1'b1;
                busy       = 1'b1;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                apb.psel    = 1'b1;
                apb.penable = 1'b1;
                busy        = 1'b1;
                if (apb.pready) begin
                    state_next  = ST_IDLE;
                    finish_xfer = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Capture the winner's request on the grant edge; the bus fields then hold
    // until the next grant, and reads leave the old write data in place.
    always_ff @(posedge pclk) begin
        if (preset) begin
            last_m1    <= 1'b1;
            owner_m1   <= 1'b0;
            apb.pwrite <= 1'b0;
            apb.paddr  <= 32'h0;
            apb.pwdata <= 32'h0;
            apb.pstrb  <= 4'h0;
        end else if (start_xfer) begin
            last_m1    <= grant_m1;
            owner_m1   <= grant_m1;
            apb.pwrite <= sel_write;
            apb.paddr  <= sel_addr;
            if (sel_write) begin
                apb.pwdata <= sel_wdata;
                apb.pstrb  <= sel_strb;
            end else begin
                apb.pstrb  <= 4'h0;
            end
        end
    end

    // Completion: pulse the owner's done for one cycle and latch the response.
    always_ff @(posedge pclk) begin
        if (preset) begin
            m0_done    <= 1'b0;
            m1_done    <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_slverr <= 1'b0;
        end else begin
            m0_done <= finish_xfer & ~owner_m1;
            m1_done <= finish_xfer & owner_m1;
            if (finish_xfer) begin
                rsp_slverr <= apb.pslverr;
                if (!apb.pwrite) begin
                    rsp_rdata <= apb.prdata;
                end
            end
        end
    end

    // Saturating increment so a stuck slave cannot wrap the counter back
    // below the timeout threshold.
    always_comb begin
        wait_inc = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;
    end

    // Count ACCESS wait states and raise the sticky timeout once the limit is
    // reached; the transfer itself keeps waiting for PREADY.
    always_ff @(posedge pclk) begin
        if (preset) begin
            wait_cnt    <= 8'h0;
            timeout_err <= 1'b0;
        end else if (state == ST_ACCESS) begin
            if (apb.pready) begin
                wait_cnt <= 8'h0;
            end else begin
                wait_cnt <= wait_inc;
                if (wait_inc >= WAIT_LIMIT_W) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule
